snake_dir_scheduler: RTL and testbench
======================================

# snake_dir_scheduler

Schedules keyboard direction commands into the snake game core. It takes the one-hot direction code from the PS/2 keyboard decoder, which is asynchronous to the system clock, and resynchronises and debounces it. It rejects illegal turns, queues up to DEPTH pending turns, and releases exactly one turn per game tick. It sits between the keyboard decoder and the snake movement/datapath logic.

## Interface
- DEPTH, 4: turn-queue entries (power of two, 2..16)
- INIT_DIR, 4'b1000: direction after reset (RIGHT)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- key_code  in  8  decoder output: UP=8'b0001, DOWN=8'b0010, LEFT=8'b0100, RIGHT=8'b1000, none=0; async to clock, level-held until next key
- enable  in  1  1 = game running; 0 = paused (keys discarded, ticks ignored)
- game_tick  in  1  one-cycle pulse per snake step
- direction  out  4  current one-hot heading
- turn  out  1  one-cycle pulse: direction changed this tick
- queue_count  out  $clog2(DEPTH)+1  pending turns
- overflow  out  1  one-cycle pulse: legal turn dropped, queue full

## Operation
- Sync: key_code[3:0] passes through two flops (s1, s2), then s3 <= s2. key_code[7:4] is ignored.
- Stability/edge detection: a candidate exists when s2 == s3 and s2 != last_seen. On a candidate, last_seen <= s2, whether or not the code is accepted. A held key therefore yields one candidate only. Re-pressing the same key yields nothing until a different code, including 0, has been seen.
- Validity: the candidate must be non-zero one-hot. 0 and multi-bit codes only update last_seen.
- Turn filter: the reference heading is tail_dir, the last enqueued direction, or `direction` when the queue is empty. The candidate is rejected if it equals tail_dir or is its opposite (UP<->DOWN, LEFT<->RIGHT).
- Push: an accepted candidate with count < DEPTH is written at the tail, and tail_dir <= candidate. If count == DEPTH, the candidate is dropped and overflow pulses. The drop does not update tail_dir.
- Pop: on game_tick with count > 0, direction <= head, head advances, and turn pulses. With count == 0, the tick does nothing.
- Simultaneous push and pop: both occur and the count is unchanged. The filter uses the pre-pop tail_dir. When the queue is empty there is no bypass: the pushed turn applies on the next tick.
- enable = 0: candidates still update last_seen but are never pushed, and ticks never pop. The queue contents are retained.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is kept separately, which resolves full vs empty.

## Timing
- Reset values: direction = INIT_DIR, turn = 0, overflow = 0, queue_count = 0. s1, s2, s3 and last_seen = 0. tail_dir tracks direction. Pointers = 0.
- A reset asserted mid-queue discards all entries on that edge. Reset overrides a simultaneous tick or push.
- Key latency: if key_code changes before edge 1, it is in s1 at edge 1, s2 at edge 2 and s3 at edge 3. The candidate is evaluated in the cycle after edge 3 and pushed at edge 4. queue_count reflects the push after edge 4.
- Tick latency: a game_tick sampled at edge k updates direction and pulses turn in the cycle after edge k, i.e. 1 cycle.
- turn and overflow are registered and high for exactly one cycle.

## Structure
- The shared package snake_pkg holds the direction localparams DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_NONE, plus an opposite(dir) function. The movement datapath uses the same package.
- One sub-module, key_sync_filter, contains s1–s3, last_seen and the one-hot check. Its outputs are cand_valid (pulse) and cand_dir[3:0].
- The FIFO, the turn filter and the pop logic live in the top module.

## Test plan
- Reset: direction = 4'b1000, counts 0. Hold key_code = 8'b0001 → queue_count = 1 four cycles later. game_tick → direction = 4'b0001, turn pulse, count 0.
- Reversal: heading RIGHT, press LEFT (8'b0100) → count stays 0, no overflow. Press RIGHT → rejected as same direction.
- Queue chain: from RIGHT, press UP, LEFT, DOWN, RIGHT (each released to 0 between presses) → count 4. A fifth legal key (UP) → overflow pulse, count 4. Four ticks → directions UP, LEFT, DOWN, RIGHT in order.
- Simultaneous: count 1 (UP), heading RIGHT. Push LEFT on the same edge as game_tick → direction UP, count 1, head = LEFT.
- Invalid/held: key_code 8'b0011 → no push. Holding 8'b0010 for 100 cycles → exactly one push.
- Reset mid-queue with count 3 and enable toggled low during ticks → after reset count 0, direction = 4'b1000. While enable = 0, ticks leave the direction unchanged.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg
// Direction encodings shared by the direction scheduler and the snake
// movement datapath, plus a helper that returns the reverse heading.
package snake_pkg;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    // Reverse heading. Anything other than a legal one-hot direction has
    // no opposite and maps to DIR_NONE.
    function automatic logic [3:0] opposite(input logic [3:0] dir);
        logic [3:0] r;
        case (dir)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_sync_filter.sv
// key_sync_filter
// Brings the keyboard decoder's direction code into the clock domain,
// waits for it to be stable, and reports each new code exactly once.
//
// Ports
//   clock       in   system clock
//   reset       in   synchronous, active-high
//   key_code    in   [3:0] one-hot direction code, async to clock
//   cand_valid  out  combinational pulse: a new, stable, one-hot code
//   cand_dir    out  [3:0] the code belonging to cand_valid
module key_sync_filter
    import snake_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_code,
    output logic       cand_valid,
    output logic [3:0] cand_dir
);

    logic [3:0] s1_q, s2_q, s3_q;
    logic [3:0] last_seen_q, last_seen_d;
    logic       cand;

    // A candidate is any stable code that differs from the last one
    // reported; it is recorded even when it is not a usable direction,
    // so releasing a key to 0 re-arms the same key.
    assign cand = (s2_q == s3_q) && (s2_q != last_seen_q);

    always_comb begin
        last_seen_d = last_seen_q;
        if (cand) begin
            last_seen_d = s2_q;
        end
    end

    assign cand_valid = cand && $onehot(s2_q);
    assign cand_dir   = s2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q        <= DIR_NONE;
            s2_q        <= DIR_NONE;
            s3_q        <= DIR_NONE;
            last_seen_q <= DIR_NONE;
        end else begin
            s1_q        <= key_code;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            last_seen_q <= last_seen_d;
        end
    end

endmodule

// File: rtl/snake_dir_scheduler.sv
// snake_dir_scheduler
// Queues legal direction changes from the keyboard and releases one per
// game tick to the snake movement logic.
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high
//   key_code     in   [7:0] keyboard decoder output, only [3:0] used
//   enable       in   1 = running; 0 = paused (no push, no pop)
//   game_tick    in   one-cycle pulse per snake step
//   direction    out  [3:0] current one-hot heading
//   turn         out  one-cycle pulse: heading changed
//   queue_count  out  pending turns
//   overflow     out  one-cycle pulse: legal turn dropped, queue full
module snake_dir_scheduler
    import snake_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] INIT_DIR = DIR_RIGHT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             key_code,
    input  logic                   enable,
    input  logic                   game_tick,
    output logic [3:0]             direction,
    output logic                   turn,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [3:0]    key_hi_unused;
    logic          cand_valid;
    logic [3:0]    cand_dir;

    logic [3:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    dir_q, dir_d;
    logic [3:0]    tail_dir_q, tail_dir_d;
    logic          turn_q, turn_d;
    logic          overflow_q, overflow_d;

    logic [3:0]    ref_dir;
    logic          accept, push, pop;

    assign key_hi_unused = key_code[7:4];

    key_sync_filter u_key_sync_filter (
        .clock      (clock),
        .reset      (reset),
        .key_code   (key_code[3:0]),
        .cand_valid (cand_valid),
        .cand_dir   (cand_dir)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dir_d      = dir_q;
        tail_dir_d = tail_dir_q;
        turn_d     = 1'b0;
        overflow_d = 1'b0;

        // Turns are judged against the last queued heading so a chain of
        // queued turns can never contain an immediate reversal. This uses
        // the pre-pop tail even when a tick pops in the same cycle.
        ref_dir = (count_q == '0) ? dir_q : tail_dir_q;
        accept  = enable && cand_valid
                  && (cand_dir != ref_dir) && (cand_dir != opposite(ref_dir));
        push    = accept && (count_q != FULL_C);
        pop     = enable && game_tick && (count_q != '0);

        if (push) begin
            wr_ptr_d   = wr_ptr_q + PW'(1);
            tail_dir_d = cand_dir;
        end
        if (accept && !push) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            dir_d    = mem_q[rd_ptr_q];
            turn_d   = 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cand_dir;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dir_q      <= INIT_DIR;
            tail_dir_q <= INIT_DIR;
            turn_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            tail_dir_q <= tail_dir_d;
            turn_q     <= turn_d;
            overflow_q <= overflow_d;
        end
    end

    assign direction   = dir_q;
    assign turn        = turn_q;
    assign queue_count = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_snake_dir_scheduler.sv
module tb_snake_dir_scheduler;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] key_code = 8'h00;
    logic       enable = 1'b1;
    logic       game_tick = 1'b0;
    logic [3:0] direction;
    logic       turn;
    logic [2:0] queue_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_turn_q[$];
    int         exp_ovf_q[$];

    snake_dir_scheduler #(.DEPTH(DEPTH), .INIT_DIR(4'b1000)) dut (
        .clock       (clock),
        .reset       (reset),
        .key_code    (key_code),
        .enable      (enable),
        .game_tick   (game_tick),
        .direction   (direction),
        .turn        (turn),
        .queue_count (queue_count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every turn / overflow pulse must match a queued expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && turn) begin
                if (exp_turn_q.size() == 0) begin
                    check("unexpected_turn", int'(direction), 0);
                end else begin
                    check("turn_dir", int'(direction), int'(exp_turn_q.pop_front()));
                end
            end
            if (!reset && overflow) begin
                if (exp_ovf_q.size() == 0) begin
                    check("unexpected_overflow", 1, 0);
                end else begin
                    check("overflow_pulse", 1, exp_ovf_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic press(input logic [7:0] code);
        @(posedge clock); #1 key_code = code;
        repeat (6) @(posedge clock);
        #1 key_code = 8'h00;
        repeat (6) @(posedge clock);
    endtask

    task automatic tick();
        @(posedge clock); #1 game_tick = 1'b1;
        @(posedge clock); #1 game_tick = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_dir", int'(direction), 8);
        check("rst_count", int'(queue_count), 0);
        check("rst_turn", int'(turn), 0);
        check("rst_ovf", int'(overflow), 0);

        // key latency: push lands at edge 4
        @(posedge clock); #1 key_code = 8'b0001;
        repeat (3) @(posedge clock);
        #1 check("lat_edge3_count", int'(queue_count), 0);
        @(posedge clock);
        #1 check("lat_edge4_count", int'(queue_count), 1);
        repeat (4) @(posedge clock);
        #1 key_code = 8'h00;
        repeat (6) @(posedge clock);
        exp_turn_q.push_back(4'b0001);
        tick();
        check("tick_dir", int'(direction), 1);
        check("tick_count", int'(queue_count), 0);

        // reversal and same-direction rejection
        do_reset();
        press(8'b0100);
        check("reverse_count", int'(queue_count), 0);
        press(8'b1000);
        check("same_count", int'(queue_count), 0);

        // queue chain + overflow
        do_reset();
        press(8'b0001);
        press(8'b0100);
        press(8'b0010);
        press(8'b1000);
        check("chain_count", int'(queue_count), 4);
        exp_ovf_q.push_back(1);
        press(8'b0001);
        check("ovf_count", int'(queue_count), 4);
        exp_turn_q.push_back(4'b0001);
        exp_turn_q.push_back(4'b0100);
        exp_turn_q.push_back(4'b0010);
        exp_turn_q.push_back(4'b1000);
        repeat (4) tick();
        check("chain_end_count", int'(queue_count), 0);
        check("chain_end_dir", int'(direction), 8);

        // simultaneous push and pop
        do_reset();
        press(8'b0001);
        check("sim_pre_count", int'(queue_count), 1);
        exp_turn_q.push_back(4'b0001);
        @(posedge clock); #1 key_code = 8'b0100;
        repeat (3) @(posedge clock);
        #1 game_tick = 1'b1;
        @(posedge clock);
        #1 game_tick = 1'b0;
        check("sim_dir", int'(direction), 1);
        check("sim_count", int'(queue_count), 1);
        repeat (3) @(posedge clock);
        #1 key_code = 8'h00;
        repeat (6) @(posedge clock);
        exp_turn_q.push_back(4'b0100);
        tick();
        check("sim_head_dir", int'(direction), 4);
        check("sim_post_count", int'(queue_count), 0);

        // invalid multi-bit code, then long hold yields one push
        press(8'b0011);
        check("multibit_count", int'(queue_count), 0);
        @(posedge clock); #1 key_code = 8'b0010;
        repeat (100) @(posedge clock);
        #1 check("held_count", int'(queue_count), 1);
        key_code = 8'h00;
        repeat (6) @(posedge clock);
        exp_turn_q.push_back(4'b0010);
        tick();
        check("held_dir", int'(direction), 2);

        // pause, then reset mid-queue
        do_reset();
        press(8'b0001);
        press(8'b0100);
        press(8'b0010);
        check("mid_count", int'(queue_count), 3);
        @(posedge clock); #1 enable = 1'b0;
        tick();
        tick();
        press(8'b1000);
        check("paused_dir", int'(direction), 8);
        check("paused_count", int'(queue_count), 3);
        @(posedge clock); #1 enable = 1'b1;
        reset = 1'b1;
        game_tick = 1'b1;
        @(posedge clock); #1 game_tick = 1'b0;
        reset = 1'b0;
        check("midrst_count", int'(queue_count), 0);
        check("midrst_dir", int'(direction), 8);
        repeat (4) @(posedge clock);
        check("midrst_turn", int'(turn), 0);

        repeat (4) @(posedge clock);
        check("leftover_turns", exp_turn_q.size(), 0);
        check("leftover_ovf", exp_ovf_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
